// File: rtl/video_timing_receiver.sv
// video_timing_receiver: decodes HS/VS/BLANK into pixel coordinates, measures timing and tracks lock.
// Define VIDEO_CRC_EN to add a per-frame CRC-16-CCITT of the locked pixel data.
module video_timing_receiver #(
   parameter int HDISP       = 800,
   parameter int VDISP       = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                       pixel_clk,
   input  logic                       pixel_rst,
   input  logic                       vid_hs,
   input  logic                       vid_vs,
   input  logic                       vid_blank,
   input  logic [23:0]                vid_rgb,
   output logic                       pix_valid,
   output logic [$clog2(HDISP+1)-1:0] pix_x,
   output logic [$clog2(VDISP+1)-1:0] pix_y,
   output logic [23:0]                pix_rgb,
   output logic                       sof,
   output logic                       eol,
   output logic                       locked,
   output logic                       err_hsize,
   output logic                       err_vsize,
   output logic [11:0]                line_period,
   output logic [10:0]                frame_lines,
   output logic [15:0]                frame_cnt,
   output logic [15:0]                frame_crc
);
   localparam int XW = $clog2(HDISP+1);
   localparam int YW = $clog2(VDISP+1);
   localparam logic [XW-1:0] HD = XW'(HDISP);
   localparam logic [XW-1:0] HL = XW'(HDISP-1);
   localparam logic [YW-1:0] VD = YW'(VDISP);
   localparam logic [3:0]    LF = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {UNLOCKED, SYNCING, LOCKED} state_t;
   state_t state_q, state_d;

   logic          hs_q, vs_q, blank_q, hs_p_q, vs_p_q, blank_p_q;
   logic [23:0]   rgb_q, prgb_q;
   logic [XW-1:0] x_q, x_d, px_q;
   logic [YW-1:0] y_q, y_d, y_inc, py_q;
   logic [11:0]   per_q, per_d, lper_q;
   logic [10:0]   hcnt_q, hcnt_d, flines_q;
   logic [15:0]   fcnt_q;
   logic [3:0]    good_q, good_d;
   logic          hs_fall, vs_fall, blank_fall, eh, ev, valid;
   logic          valid_q, sof_q, eol_q, locked_q, eh_q, ev_q;

   always_comb begin
      hs_fall    = hs_p_q & ~hs_q;
      vs_fall    = vs_p_q & ~vs_q;
      blank_fall = blank_p_q & ~blank_q;
      eh         = blank_fall && x_q != HD;
      // a line ending on the VS edge is counted before the frame size check
      y_inc      = (blank_fall && y_q != '1) ? y_q + 1'b1 : y_q;
      ev         = vs_fall && y_inc != VD;
      x_d        = blank_q ? ((x_q == '1) ? x_q : x_q + 1'b1) : (blank_fall ? '0 : x_q);
      y_d        = vs_fall ? '0 : y_inc;
      per_d      = hs_fall ? 12'd1 : ((per_q == '1) ? per_q : per_q + 1'b1);
      hcnt_d     = vs_fall ? {10'd0, hs_fall} : ((hs_fall && hcnt_q != '1) ? hcnt_q + 1'b1 : hcnt_q);
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      if (vs_fall && state_q == UNLOCKED) begin
         state_d = SYNCING;
         good_d  = '0;
      end else if (vs_fall && state_q == SYNCING) begin
         good_d  = good_q + 1'b1;
         state_d = (good_d == LF) ? LOCKED : SYNCING;
      end
      if ((eh || ev) && state_q != UNLOCKED) state_d = UNLOCKED;
      valid = blank_q && state_d == LOCKED;
   end

   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         {hs_q, vs_q, blank_q, hs_p_q, vs_p_q, blank_p_q} <= '0;
         rgb_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         per_q    <= '0;
         hcnt_q   <= '0;
         good_q   <= '0;
         state_q  <= UNLOCKED;
         {valid_q, sof_q, eol_q, locked_q, eh_q, ev_q} <= '0;
         px_q     <= '0;
         py_q     <= '0;
         prgb_q   <= '0;
         lper_q   <= '0;
         flines_q <= '0;
         fcnt_q   <= '0;
      end else begin
         {hs_q, vs_q, blank_q} <= {vid_hs, vid_vs, vid_blank};
         {hs_p_q, vs_p_q, blank_p_q} <= {hs_q, vs_q, blank_q};
         rgb_q    <= vid_rgb;
         x_q      <= x_d;
         y_q      <= y_d;
         per_q    <= per_d;
         hcnt_q   <= hcnt_d;
         good_q   <= good_d;
         state_q  <= state_d;
         valid_q  <= valid;
         px_q     <= x_q;
         py_q     <= y_q;
         prgb_q   <= rgb_q;
         sof_q    <= valid && x_q == '0 && y_q == '0;
         eol_q    <= valid && x_q == HL;
         locked_q <= state_d == LOCKED;
         eh_q     <= eh;
         ev_q     <= ev;
         if (hs_fall) lper_q <= per_q;
         if (vs_fall) begin
            flines_q <= hcnt_q;
            fcnt_q   <= fcnt_q + 1'b1;
         end
      end
   end

`ifdef VIDEO_CRC_EN
   logic [15:0] crc_q, crc_d, fcrc_q, fcrc_d;

   function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 23; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction

   always_comb begin
      crc_d  = (state_q == LOCKED && (vs_fall || state_d != LOCKED)) ? 16'hFFFF : (valid ? crc24(crc_q, rgb_q) : crc_q);
      fcrc_d = (state_q == LOCKED && state_d == LOCKED && vs_fall) ? crc_q : fcrc_q;
   end

   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         crc_q  <= 16'hFFFF;
         fcrc_q <= '0;
      end else begin
         crc_q  <= crc_d;
         fcrc_q <= fcrc_d;
      end
   end

   assign frame_crc = fcrc_q;
`else
   assign frame_crc = 16'h0000;
`endif

   assign pix_valid   = valid_q;
   assign pix_x       = px_q;
   assign pix_y       = py_q;
   assign pix_rgb     = prgb_q;
   assign sof         = sof_q;
   assign eol         = eol_q;
   assign locked      = locked_q;
   assign err_hsize   = eh_q;
   assign err_vsize   = ev_q;
   assign line_period = lper_q;
   assign frame_lines = flines_q;
   assign frame_cnt   = fcnt_q;
endmodule
